// File: rtl/register_scalar_wb_arbiter.sv
// Round-robin writeback arbiter for the scalar register file write port, with a pending-write scoreboard.
// Optional: define REG_ZERO_HARDWIRED_EN to make register 0 constant zero (no write, never busy).
module register_scalar_wb_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_rd,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wd,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        iss_valid,
  input  logic [ADDR_W-1:0]           iss_rd,
  input  logic [ADDR_W-1:0]           RS1,
  input  logic [ADDR_W-1:0]           RS2,
  input  logic [ADDR_W-1:0]           RS3,
  output logic                        rs1_busy,
  output logic                        rs2_busy,
  output logic                        rs3_busy,
  output logic                        iss_stall,
  output logic [(2**ADDR_W)-1:0]      busy,
  output logic                        wr_enable,
  output logic [ADDR_W-1:0]           RD,
  output logic [DATA_W-1:0]           WD
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam int unsigned PTR_W    = $clog2(NUM_REQ);

  logic [ADDR_W-1:0]   rd_arr [NUM_REQ];
  logic [DATA_W-1:0]   wd_arr [NUM_REQ];

  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   wd_q, wd_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  logic                found_c;
  logic [PTR_W-1:0]    gidx_c;
  logic [NUM_REQ-1:0]  grant_c;
  logic [ADDR_W-1:0]   sel_rd_c;
  logic [DATA_W-1:0]   sel_wd_c;
  int unsigned         idx_c;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign rd_arr[gi] = req_rd[gi*ADDR_W +: ADDR_W];
    assign wd_arr[gi] = req_wd[gi*DATA_W +: DATA_W];
  end

  // First valid requester at or after the pointer, wrapping; no grant while in reset.
  always_comb begin
    found_c = 1'b0;
    gidx_c  = '0;
    idx_c   = 0;
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        idx_c = (32'(ptr_q) + i) % NUM_REQ;
        if (!found_c && req_valid[PTR_W'(idx_c)]) begin
          found_c = 1'b1;
          gidx_c  = PTR_W'(idx_c);
        end
      end
    end
    grant_c  = found_c ? (NUM_REQ'(1) << gidx_c) : '0;
    sel_rd_c = rd_arr[gidx_c];
    sel_wd_c = wd_arr[gidx_c];
  end

  assign req_ready = grant_c;

  // Next-state for the write port, pointer and scoreboard.
  always_comb begin
    ptr_d   = ptr_q;
    wr_en_d = 1'b0;
    rd_d    = rd_q;
    wd_d    = wd_q;
    busy_d  = busy_q;
    if (found_c) begin
      wr_en_d = 1'b1;
      rd_d    = sel_rd_c;
      wd_d    = sel_wd_c;
      ptr_d   = (gidx_c == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_c + PTR_W'(1);
`ifdef REG_ZERO_HARDWIRED_EN
      if (sel_rd_c == '0) wr_en_d = 1'b0;
`endif
      busy_d[sel_rd_c] = 1'b0;
    end
    // Issue is applied after the clear so a same-edge set wins.
    if (iss_valid) busy_d[iss_rd] = 1'b1;
`ifdef REG_ZERO_HARDWIRED_EN
    busy_d[0] = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= '0;
      wr_en_q <= 1'b0;
      rd_q    <= '0;
      wd_q    <= '0;
      busy_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      wr_en_q <= wr_en_d;
      rd_q    <= rd_d;
      wd_q    <= wd_d;
      busy_q  <= busy_d;
    end
  end

  assign wr_enable = wr_en_q;
  assign RD        = rd_q;
  assign WD        = wd_q;
  assign busy      = busy_q;
  assign rs1_busy  = busy_q[RS1];
  assign rs2_busy  = busy_q[RS2];
  assign rs3_busy  = busy_q[RS3];
  assign iss_stall = iss_valid & busy_q[iss_rd];

endmodule

// File: tb/tb_register_scalar_wb_arbiter.sv
// Scoreboard bench for register_scalar_wb_arbiter: expected register-file writes are queued at
// handshake time and popped by a monitor whenever wr_enable is seen.
module tb_register_scalar_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [11:0] req_rd;
  logic [95:0] req_wd;
  logic [2:0]  req_ready;
  logic        iss_valid;
  logic [3:0]  iss_rd;
  logic [3:0]  RS1, RS2, RS3;
  logic        rs1_busy, rs2_busy, rs3_busy;
  logic        iss_stall;
  logic [15:0] busy;
  logic        wr_enable;
  logic [3:0]  RD;
  logic [31:0] WD;

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] wd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  register_scalar_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rd(req_rd), .req_wd(req_wd), .req_ready(req_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .RS1(RS1), .RS2(RS2), .RS3(RS3),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rs3_busy(rs3_busy),
    .iss_stall(iss_stall), .busy(busy),
    .wr_enable(wr_enable), .RD(RD), .WD(WD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] rd, input logic [31:0] wd);
    exp_t e;
    e.rd = rd;
    e.wd = wd;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] rd, input logic [31:0] wd);
    req_valid[i]       = v;
    req_rd[i*4 +: 4]   = rd;
    req_wd[i*32 +: 32] = wd;
  endtask

  // Write-port monitor: every wr_enable must match the oldest queued expectation.
  always @(negedge clk) begin
    if (wr_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got RD=%0h WD=%0h expected no write", RD, WD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_RD", 32'(RD), 32'(e.rd));
        chk("wr_WD", WD, e.wd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] wdv [3];
    int g;
    int gprev;

    rst = 1'b1;
    req_valid = '0; req_rd = '0; req_wd = '0;
    iss_valid = 1'b0; iss_rd = '0;
    RS1 = '0; RS2 = '0; RS3 = '0;
    #1 rst = 1'b0;

    // Reset with all requesters valid, then release and rotate through six grants.
    for (int i = 0; i < 3; i++) wdv[i] = 32'h100 + 32'(i);
    @(negedge clk);
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 4'(8 + i), wdv[i]);
    #1;
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_wr_enable", 32'(wr_enable), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_RD", 32'(RD), 32'h0);
    chk("reset_WD", WD, 32'h0);
    rst = 1'b1;
    #1;
    gprev = 0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(negedge clk);
        wdv[gprev] = wdv[gprev] + 32'h10;
        set_req(gprev, 1'b1, 4'(8 + gprev), wdv[gprev]);
        #1;
      end
      g = k % 3;
      chk("rr_grant", 32'(req_ready), 32'(3'b001 << g));
      push(4'(8 + g), wdv[g]);
      gprev = g;
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("rr_last_write", 32'(wr_enable), 32'h1);

    // Single write from requester 1.
    @(negedge clk);
    set_req(1, 1'b1, 4'd3, 32'd99);
    #1;
    chk("single_ready", 32'(req_ready), 32'b010);
    push(4'd3, 32'd99);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("single_wr_enable", 32'(wr_enable), 32'h1);
    @(negedge clk);
    #1;
    chk("single_wr_drop", 32'(wr_enable), 32'h0);

    // Scoreboard set by issue, cleared by writeback.
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 4'd5; RS2 = 4'd5;
    #1;
    chk("iss5_stall", 32'(iss_stall), 32'h0);
    @(negedge clk);
    iss_valid = 1'b0;
    #1;
    chk("busy5_set", 32'(busy[5]), 32'h1);
    chk("rs2_busy_set", 32'(rs2_busy), 32'h1);
    chk("rs1_busy_clear", 32'(rs1_busy), 32'h0);
    set_req(0, 1'b1, 4'd5, 32'd255);
    #1;
    chk("wb5_ready", 32'(req_ready), 32'b001);
    chk("rs2_busy_before_edge", 32'(rs2_busy), 32'h1);
    push(4'd5, 32'd255);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("busy5_cleared", 32'(busy[5]), 32'h0);
    chk("rs2_busy_cleared", 32'(rs2_busy), 32'h0);

    // Same-edge issue and writeback to reg 5: set wins.
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 4'd5;
    set_req(0, 1'b1, 4'd5, 32'd256);
    #1;
    chk("same_edge_ready", 32'(req_ready), 32'b001);
    push(4'd5, 32'd256);
    @(negedge clk);
    iss_valid = 1'b0; req_valid = '0;
    #1;
    chk("busy5_set_wins", 32'(busy[5]), 32'h1);

    // WAW hazard on reg 4.
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 4'd4; RS3 = 4'd4;
    #1;
    chk("iss4_first_stall", 32'(iss_stall), 32'h0);
    @(negedge clk);
    #1;
    chk("iss4_waw_stall", 32'(iss_stall), 32'h1);
    chk("rs3_busy4", 32'(rs3_busy), 32'h1);
    @(negedge clk);
    iss_valid = 1'b0;
    #1;
    chk("busy_vec", 32'(busy), 32'h0030);

    // Mid-stream reset discards the in-flight write (no expectation queued).
    @(negedge clk);
    set_req(2, 1'b1, 4'd7, 32'd77);
    #1;
    chk("midrst_ready", 32'(req_ready), 32'b100);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_wr_enable", 32'(wr_enable), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_ready_low", 32'(req_ready), 32'h0);
    @(negedge clk);
    req_valid = '0;
    #1 rst = 1'b1;

    // Register 0 behaviour, with or without hardwiring.
    @(negedge clk);
    set_req(0, 1'b1, 4'd0, 32'd7);
    #1;
    chk("r0_ready", 32'(req_ready), 32'b001);
`ifndef REG_ZERO_HARDWIRED_EN
    push(4'd0, 32'd7);
`endif
    @(negedge clk);
    req_valid = '0;
    #1;
`ifdef REG_ZERO_HARDWIRED_EN
    chk("r0_wr_enable", 32'(wr_enable), 32'h0);
`else
    chk("r0_wr_enable", 32'(wr_enable), 32'h1);
`endif
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 4'd0; RS1 = 4'd0;
    @(negedge clk);
    iss_valid = 1'b0;
    #1;
`ifdef REG_ZERO_HARDWIRED_EN
    chk("r0_busy", 32'(busy[0]), 32'h0);
    chk("r0_rs1_busy", 32'(rs1_busy), 32'h0);
`else
    chk("r0_busy", 32'(busy[0]), 32'h1);
    chk("r0_rs1_busy", 32'(rs1_busy), 32'h1);
`endif

    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
